// File: rtl/mm_bridge_seq.sv
// Sequencer that stages Montgomery operands from a word-wide BRAM into a FIOS core
// and writes the core's result back to BRAM; p can be reused and the result squared.
module mm_bridge_seq #(
  parameter int W  = 17,
  parameter int s  = 8,
  parameter int AW = 32
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [1:0]     mode_i,
  input  logic [W-1:0]   BRAM_dout_i,
  output logic [W-1:0]   BRAM_din_o,
  output logic           BRAM_we_o,
  output logic [AW-1:0]  BRAM_addr_o,
  output logic           BRAM_en_o,
  output logic           core_start_o,
  output logic [W-1:0]   core_p_prime_0_o,
  output logic [s*W-1:0] core_a_o,
  output logic [W-1:0]   core_b_o,
  output logic [W-1:0]   core_p_o,
  input  logic           core_b_fetch_i,
  input  logic           core_p_fetch_i,
  input  logic           core_res_push_i,
  input  logic [W-1:0]   core_res_i,
  input  logic           core_done_i,
  output logic           busy_o,
  output logic           done_o
);

  localparam int LA = $clog2(4*s+1);
  localparam logic [LA-1:0] ADDR_P_HI    = LA'(s);
  localparam logic [LA-1:0] ADDR_A_LO    = LA'(s+1);
  localparam logic [LA-1:0] ADDR_A_HI    = LA'(2*s);
  localparam logic [LA-1:0] ADDR_LAST_LD = LA'(3*s);
  localparam logic [LA-1:0] ADDR_RES_LO  = LA'(3*s+1);
  localparam logic [LA-1:0] ADDR_RES_HI  = LA'(4*s);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN, S_STORE, S_DONE} state_t;
  typedef enum logic [1:0] {M_FULL, M_REUSE, M_SQUARE} mode_t;

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [LA-1:0]   cnt_q, cnt_d;
  logic            pValid_q, pValid_d;

  logic [W-1:0]    pp_q;
  logic [s*W-1:0]  p_q, a_q, b_q, res_q;
  logic            rdValid1_q, rdValid2_q;
  logic [LA-1:0]   rdAddr1_q, rdAddr2_q;
  logic [W-1:0]    rdData_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      mode_q   <= M_FULL;
      cnt_q    <= '0;
      pValid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      pValid_q <= pValid_d;
    end
  end

  // cnt_q is the BRAM address in LOAD/STORE and the cycle counter in DRAIN
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    pValid_d = pValid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (mode_i)
            2'd1:    mode_d = pValid_q ? M_REUSE  : M_FULL;
            2'd2:    mode_d = pValid_q ? M_SQUARE : M_FULL;
            default: mode_d = M_FULL;
          endcase
          if (mode_d == M_SQUARE) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = (mode_d == M_REUSE) ? ADDR_A_LO : '0;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == ADDR_LAST_LD) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          if (mode_q == M_FULL) pValid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + LA'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == LA'(1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LA'(1);
        end
      end
      S_RUN: begin
        if (core_done_i) begin
          state_d = S_STORE;
          cnt_d   = ADDR_RES_LO;
        end
      end
      S_STORE: begin
        if (cnt_q == ADDR_RES_HI) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LA'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BRAM_en_o    = 1'b0;
    BRAM_we_o    = 1'b0;
    BRAM_addr_o  = '0;
    BRAM_din_o   = '0;
    core_start_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        BRAM_en_o   = 1'b1;
        BRAM_addr_o = AW'(cnt_q);
      end
      S_DRAIN: core_start_o = (cnt_q == LA'(1));
      S_STORE: begin
        BRAM_en_o   = 1'b1;
        BRAM_we_o   = 1'b1;
        BRAM_addr_o = AW'(cnt_q);
        BRAM_din_o  = res_q[W-1:0];
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Read pipeline: address tag follows BRAM latency, then one register stage before the shift
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rdValid1_q <= 1'b0;
      rdValid2_q <= 1'b0;
      rdAddr1_q  <= '0;
      rdAddr2_q  <= '0;
      rdData_q   <= '0;
      pp_q       <= '0;
      p_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      rdValid1_q <= (state_q == S_LOAD);
      rdAddr1_q  <= cnt_q;
      rdValid2_q <= rdValid1_q;
      rdAddr2_q  <= rdAddr1_q;
      rdData_q   <= BRAM_dout_i;

      if (rdValid2_q) begin
        if (rdAddr2_q == '0)             pp_q <= rdData_q;
        else if (rdAddr2_q <= ADDR_P_HI) p_q  <= {rdData_q, p_q[s*W-1:W]};
        else if (rdAddr2_q <= ADDR_A_HI) a_q  <= {rdData_q, a_q[s*W-1:W]};
        else                             b_q  <= {rdData_q, b_q[s*W-1:W]};
      end

      if (state_q == S_DRAIN && cnt_q == '0 && mode_q == M_SQUARE) begin
        a_q <= res_q;
        b_q <= res_q;
      end

      // Fetches rotate rather than shift so operands survive for REUSE_P/SQUARE
      if (state_q == S_RUN) begin
        if (core_b_fetch_i)  b_q   <= {b_q[W-1:0], b_q[s*W-1:W]};
        if (core_p_fetch_i)  p_q   <= {p_q[W-1:0], p_q[s*W-1:W]};
        if (core_res_push_i) res_q <= {core_res_i, res_q[s*W-1:W]};
      end

      if (state_q == S_STORE) res_q <= {res_q[W-1:0], res_q[s*W-1:W]};
    end
  end

  assign core_p_prime_0_o = pp_q;
  assign core_a_o         = a_q;
  assign core_b_o         = b_q[W-1:0];
  assign core_p_o         = p_q[W-1:0];

endmodule

// File: tb/tb_mm_bridge_seq.sv
// Directed bench for mm_bridge_seq with s=4, W=17: BRAM model, core stand-in driven by tasks.
module tb_mm_bridge_seq;

  localparam int W  = 17;
  localparam int S  = 4;
  localparam int AW = 32;

  localparam int EV_PFETCH = 0;
  localparam int EV_BFETCH = 1;
  localparam int EV_PUSH   = 2;
  localparam int EV_DONE   = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           startIn = 1'b0;
  logic [1:0]     modeIn = 2'd0;
  logic [W-1:0]   bramDout = '0;
  logic [W-1:0]   bramDin;
  logic           bramWe, bramEn;
  logic [AW-1:0]  bramAddr;
  logic           coreStart;
  logic [W-1:0]   corePp, coreB, coreP;
  logic [S*W-1:0] coreA;
  logic           bFetch = 1'b0, pFetch = 1'b0, resPush = 1'b0, coreDone = 1'b0;
  logic [W-1:0]   coreRes = '0;
  logic           busy, done;

  mm_bridge_seq #(.W(W), .s(S), .AW(AW)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(startIn), .mode_i(modeIn),
    .BRAM_dout_i(bramDout), .BRAM_din_o(bramDin), .BRAM_we_o(bramWe),
    .BRAM_addr_o(bramAddr), .BRAM_en_o(bramEn), .core_start_o(coreStart),
    .core_p_prime_0_o(corePp), .core_a_o(coreA), .core_b_o(coreB), .core_p_o(coreP),
    .core_b_fetch_i(bFetch), .core_p_fetch_i(pFetch), .core_res_push_i(resPush),
    .core_res_i(coreRes), .core_done_i(coreDone), .busy_o(busy), .done_o(done)
  );

  always #5 clock = ~clock;

  logic [W-1:0] mem [0:16];
  always @(posedge clock) begin
    if (bramEn) begin
      if (bramWe) mem[bramAddr[4:0]] <= bramDin;
      bramDout <= mem[bramAddr[4:0]];
    end
  end

  int checkCount = 0;
  int passCount  = 0;
  int cyc = 0;
  int acceptCycle = 0, startCycle = 0, doneCycle = 0;
  int startCount = 0, doneCount = 0;
  logic [S*W-1:0] snapA;
  logic [W-1:0]   snapP, snapPP, snapB;
  logic [31:0] rdAddrQ[$], wrAddrQ[$], wrDataQ[$];
  int rdCycQ[$], wrCycQ[$];

  // Observer samples on the falling edge, away from the DUT's active edge
  always @(negedge clock) begin
    cyc++;
    if (bramEn && !bramWe) begin rdAddrQ.push_back(bramAddr); rdCycQ.push_back(cyc); end
    if (bramEn && bramWe) begin
      wrAddrQ.push_back(bramAddr); wrDataQ.push_back(32'(bramDin)); wrCycQ.push_back(cyc);
    end
    if (coreStart) begin
      startCycle = cyc; startCount++;
      snapA = coreA; snapP = coreP; snapPP = corePp; snapB = coreB;
    end
    if (done) begin doneCycle = cyc; doneCount++; end
    if (startIn && !busy && !reset) acceptCycle = cyc;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic applyStimulus(input logic [1:0] md);
    rdAddrQ.delete(); rdCycQ.delete(); wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
    startIn = 1'b1; modeIn = md;
    tick();
    startIn = 1'b0;
  endtask

  task automatic coreEvent(input int kind, input logic [W-1:0] data);
    case (kind)
      EV_PFETCH: pFetch = 1'b1;
      EV_BFETCH: bFetch = 1'b1;
      EV_PUSH:   begin resPush = 1'b1; coreRes = data; end
      default:   coreDone = 1'b1;
    endcase
    tick();
    pFetch = 1'b0; bFetch = 1'b0; resPush = 1'b0; coreDone = 1'b0; coreRes = '0;
  endtask

  task automatic waitCoreStart(input string tag);
    int n0 = startCount;
    int seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      if (startCount != n0) seen = 1; else tick();
    end
    checkOutput({tag, "_coreStartSeen"}, 128'(seen), 128'd1);
  endtask

  task automatic waitDone(input string tag);
    int n0 = doneCount;
    int seen = 0;
    for (int i = 0; i < 60 && seen == 0; i++) begin
      if (doneCount != n0) seen = 1; else tick();
    end
    checkOutput({tag, "_doneSeen"}, 128'(seen), 128'd1);
  endtask

  task automatic checkReads(input string tag, input int n, input int firstAddr);
    int errs = 0;
    checkOutput({tag, "_readCount"}, 128'(rdAddrQ.size()), 128'(n));
    for (int i = 0; i < rdAddrQ.size(); i++)
      if (rdAddrQ[i] != 32'(firstAddr + i) || rdCycQ[i] != rdCycQ[0] + i) errs++;
    checkOutput({tag, "_readSeq"}, 128'(errs), 128'd0);
  endtask

  task automatic checkWrites(input string tag);
    int errs = 0;
    checkOutput({tag, "_writeCount"}, 128'(wrAddrQ.size()), 128'd4);
    for (int i = 0; i < wrAddrQ.size(); i++)
      if (wrAddrQ[i] != 32'(13 + i) || wrDataQ[i] != 32'(16 + i) || wrCycQ[i] != wrCycQ[0] + i)
        errs++;
    checkOutput({tag, "_writeSeq"}, 128'(errs), 128'd0);
    if (wrCycQ.size() > 0)
      checkOutput({tag, "_doneAfterWrite"}, 128'(doneCycle - wrCycQ[wrCycQ.size()-1]), 128'd1);
  endtask

  initial begin
    int d0, s0;
    mem[0] = 17'h1_2345;
    for (int i = 1; i <= 12; i++) mem[i] = W'(i);
    for (int i = 13; i <= 16; i++) mem[i] = '0;

    tick(); tick();
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_en", 128'(bramEn), 128'd0);
    checkOutput("rst_addr", 128'(bramAddr), 128'd0);
    checkOutput("rst_coreA", 128'(coreA), 128'd0);
    reset = 1'b0;

    // FULL load and write-back
    applyStimulus(2'd0);
    waitCoreStart("full");
    checkReads("full", 13, 0);
    checkOutput("full_latency", 128'(startCycle - acceptCycle), 128'd15);
    checkOutput("full_coreA", 128'(snapA), 128'({17'd8, 17'd7, 17'd6, 17'd5}));
    checkOutput("full_pp", 128'(snapPP), 128'h1_2345);
    checkOutput("full_busyRun", 128'(busy), 128'd1);
    checkOutput("full_bLow", 128'(coreB), 128'd9);
    for (int k = 0; k < 4; k++) begin
      checkOutput("full_pRot", 128'(coreP), 128'(k + 1));
      coreEvent(EV_PFETCH, '0);
    end
    checkOutput("full_pIntact", 128'(coreP), 128'd1);
    coreEvent(EV_BFETCH, '0);
    checkOutput("full_bRot", 128'(coreB), 128'd10);
    for (int k = 0; k < 3; k++) coreEvent(EV_BFETCH, '0);
    checkOutput("full_bIntact", 128'(coreB), 128'd9);
    for (int k = 0; k < 4; k++) coreEvent(EV_PUSH, W'(16 + k));
    d0 = doneCount;
    coreEvent(EV_DONE, '0);
    waitDone("full");
    checkWrites("full");
    checkOutput("full_mem16", 128'(mem[16]), 128'h13);
    checkOutput("full_idleBusy", 128'(busy), 128'd0);
    tick(); tick();
    checkOutput("full_donePulses", 128'(doneCount - d0), 128'd1);

    // REUSE_P with fresh a and b
    for (int i = 0; i < 4; i++) begin mem[5+i] = W'(33 + i); mem[9+i] = W'(49 + i); end
    applyStimulus(2'd1);
    waitCoreStart("reuse");
    checkReads("reuse", 8, 5);
    checkOutput("reuse_latency", 128'(startCycle - acceptCycle), 128'd10);
    checkOutput("reuse_pLow", 128'(snapP), 128'd1);
    checkOutput("reuse_coreA", 128'(snapA), 128'({17'h24, 17'h23, 17'h22, 17'h21}));
    checkOutput("reuse_bLow", 128'(coreB), 128'h31);
    coreEvent(EV_DONE, '0);
    waitDone("reuse");
    checkWrites("reuse");

    // SQUARE from the intact result
    applyStimulus(2'd2);
    waitCoreStart("square");
    checkOutput("square_readCount", 128'(rdAddrQ.size()), 128'd0);
    checkOutput("square_latency", 128'(startCycle - acceptCycle), 128'd2);
    checkOutput("square_coreA", 128'(snapA), 128'({17'h13, 17'h12, 17'h11, 17'h10}));
    checkOutput("square_bLow", 128'(snapB), 128'h10);
    coreEvent(EV_DONE, '0);
    waitDone("square");

    // Reset in RUN clears p_valid, so a following SQUARE runs as FULL
    applyStimulus(2'd0);
    waitCoreStart("abort");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_coreA", 128'(coreA), 128'd0);
    checkOutput("abort_pLow", 128'(coreP), 128'd0);
    d0 = doneCount;
    coreEvent(EV_DONE, '0);
    tick(); tick(); tick();
    checkOutput("stray_done", 128'(doneCount - d0), 128'd0);
    checkOutput("stray_busy", 128'(busy), 128'd0);
    applyStimulus(2'd2);
    waitCoreStart("sqAsFull");
    checkReads("sqAsFull", 13, 0);
    checkOutput("sqAsFull_latency", 128'(startCycle - acceptCycle), 128'd15);
    coreEvent(EV_DONE, '0);
    waitDone("sqAsFull");

    // start held high: one operation per IDLE visit
    s0 = startCount;
    startIn = 1'b1; modeIn = 2'd0;
    waitCoreStart("hold1");
    coreEvent(EV_DONE, '0);
    waitDone("hold1");
    checkOutput("hold_idleVisit", 128'(busy), 128'd0);
    tick();
    checkOutput("hold_reaccept", 128'(busy), 128'd1);
    startIn = 1'b0;
    waitCoreStart("hold2");
    checkOutput("hold_startCount", 128'(startCount - s0), 128'd2);
    coreEvent(EV_DONE, '0);
    waitDone("hold2");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
